// File: rtl/soc_bus_pkg.sv
// Shared SoC data-bus definitions: bridge FSM states, address regions and the default memory map.
// The bridge top and the region decoder both import this package.
package soc_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } bridge_state_t;

    typedef enum logic [1:0] {
        RAM      = 2'd0,
        PERIPH   = 2'd1,
        UNMAPPED = 2'd2
    } region_t;

    localparam int          DEF_N_SLV        = 4;
    localparam int          DEF_PADDR_W      = 3;
    localparam int          DEF_PDATA_W      = 8;
    localparam logic [31:0] DEF_RAM_TOP      = 32'h0000_0FFF;
    localparam logic [31:0] DEF_PERIPH_BASE  = 32'h0001_0000;
    localparam int          DEF_SLV_WIN_BITS = 8;
    localparam int          DEF_TIMEOUT_CYC  = 16;

    // Produces a one-hot slave select; callers truncate the result to their slave count.
    function automatic logic [31:0] onehot32(input logic [4:0] idx);
        onehot32 = 32'd1 << idx;
    endfunction

endpackage

// File: rtl/apb_multi_slave_bridge_if.sv
// APB bus bundle shared by the bridge (master side) and the attached slaves.
// Read data, ready and error are concatenated per slave, with slave k in slice k.
interface apb_multi_slave_bridge_if #(
    parameter int N_SLV   = 4,
    parameter int PADDR_W = 3,
    parameter int PDATA_W = 8
) ();
    logic [N_SLV-1:0]         psel;
    logic                     penable;
    logic                     pwrite;
    logic [PADDR_W-1:0]       paddr;
    logic [PDATA_W-1:0]       pwdata;
    logic [N_SLV*PDATA_W-1:0] prdata;
    logic [N_SLV-1:0]         pready;
    logic [N_SLV-1:0]         pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/bus_region_decode.sv
// Combinational address decoder: classifies a byte address as RAM, APB peripheral or unmapped,
// and extracts the slave index. Kept separate so an instruction-side bridge can reuse it.
module bus_region_decode
    import soc_bus_pkg::*;
#(
    parameter int          N_SLV        = DEF_N_SLV,
    parameter int          SLV_WIN_BITS = DEF_SLV_WIN_BITS,
    parameter logic [31:0] RAM_TOP      = DEF_RAM_TOP,
    parameter logic [31:0] PERIPH_BASE  = DEF_PERIPH_BASE
) (
    input  logic [31:0]              addr,
    output region_t                  region,
    output logic [$clog2(N_SLV)-1:0] idx
);
    localparam int IDX_W  = $clog2(N_SLV);
    localparam int HI_LSB = SLV_WIN_BITS + IDX_W;

    // RAM takes priority; a peripheral hit needs the window tag to match and an existing slave.
    always_comb begin
        idx    = addr[SLV_WIN_BITS +: IDX_W];
        region = UNMAPPED;
        if (addr <= RAM_TOP) begin
            region = RAM;
        end else if ((addr[31:HI_LSB] == PERIPH_BASE[31:HI_LSB]) &&
                     (32'(idx) < 32'(N_SLV))) begin
            region = PERIPH;
        end else begin
            region = UNMAPPED;
        end
    end

endmodule

// File: rtl/apb_multi_slave_bridge.sv
// CPU data-port bridge: zero-wait RAM pass-through, APB SETUP/ACCESS sequencing to N_SLV slaves
// with pipeline stall and PREADY timeout, and a one-cycle error flag for faults and holes in the map.
module apb_multi_slave_bridge
    import soc_bus_pkg::*;
#(
    parameter int          N_SLV        = DEF_N_SLV,
    parameter int          PADDR_W      = DEF_PADDR_W,
    parameter int          PDATA_W      = DEF_PDATA_W,
    parameter logic [31:0] RAM_TOP      = DEF_RAM_TOP,
    parameter logic [31:0] PERIPH_BASE  = DEF_PERIPH_BASE,
    parameter int          SLV_WIN_BITS = DEF_SLV_WIN_BITS,
    parameter int          TIMEOUT_CYC  = DEF_TIMEOUT_CYC
) (
    input  logic                        PCLK,
    input  logic                        PRESETn,
    input  logic [31:0]                 cpu_addr,
    input  logic [31:0]                 cpu_wdata,
    input  logic                        cpu_mem_write,
    input  logic                        cpu_mem_read,
    output logic [31:0]                 cpu_rdata,
    output logic                        cpu_stall,
    output logic                        cpu_err,
    output logic                        ram_cs,
    output logic                        ram_we,
    input  logic [31:0]                 ram_rdata,
    apb_multi_slave_bridge_if.master    apb
);
    localparam int IDX_W = $clog2(N_SLV);
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYC > 0) ? CNT_W'(TIMEOUT_CYC - 1) : '0;
    localparam bit TIMEOUT_EN = (TIMEOUT_CYC != 0);

    bridge_state_t      state_r;
    bridge_state_t      state_nxt_s;
    region_t            region_s;
    logic [IDX_W-1:0]   idx_s;
    logic               req_s;
    logic               launch_s;
    logic               sel_ready_s;
    logic               sel_err_s;
    logic [PDATA_W-1:0] sel_rdata_s;
    logic               timeout_s;

    logic [IDX_W-1:0]   idx_r;
    logic [PADDR_W-1:0] paddr_r;
    logic [PDATA_W-1:0] pwdata_r;
    logic               pwrite_r;
    logic [N_SLV-1:0]   psel_r;
    logic               penable_r;
    logic [31:0]        rdata_r;
    logic               err_r;
    logic [CNT_W-1:0]   cnt_r;

    // Only the low store bits reach APB; the rest is intentionally dropped.
    logic unused_s;
    assign unused_s = ^cpu_wdata;

    bus_region_decode #(
        .N_SLV        (N_SLV),
        .SLV_WIN_BITS (SLV_WIN_BITS),
        .RAM_TOP      (RAM_TOP),
        .PERIPH_BASE  (PERIPH_BASE)
    ) u_decode (
        .addr   (cpu_addr),
        .region (region_s),
        .idx    (idx_s)
    );

    assign req_s       = cpu_mem_read | cpu_mem_write;
    assign launch_s    = (state_r == IDLE) && req_s && (region_s == PERIPH);
    assign sel_ready_s = apb.pready[idx_r];
    assign sel_err_s   = apb.pslverr[idx_r];
    assign sel_rdata_s = apb.prdata[int'(idx_r) * PDATA_W +: PDATA_W];
    assign timeout_s   = TIMEOUT_EN && (cnt_r == CNT_LAST);

    assign apb.psel    = psel_r;
    assign apb.penable = penable_r;
    assign apb.pwrite  = pwrite_r;
    assign apb.paddr   = paddr_r;
    assign apb.pwdata  = pwdata_r;

    // FSM state register.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and CPU/RAM-side outputs; RAM and unmapped accesses finish within the IDLE cycle.
    always_comb begin
        state_nxt_s = state_r;
        cpu_stall   = 1'b0;
        cpu_err     = 1'b0;
        cpu_rdata   = 32'h0000_0000;
        ram_cs      = 1'b0;
        ram_we      = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_s) begin
                    case (region_s)
                        RAM: begin
                            ram_cs    = 1'b1;
                            ram_we    = cpu_mem_write;
                            cpu_rdata = ram_rdata;
                        end
                        PERIPH: begin
                            cpu_stall   = 1'b1;
                            state_nxt_s = SETUP;
                        end
                        UNMAPPED: cpu_err = 1'b1;
                        default:  cpu_err = 1'b1;
                    endcase
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SETUP: begin
                cpu_stall   = 1'b1;
                state_nxt_s = ACCESS;
            end
            ACCESS: begin
                cpu_stall = 1'b1;
                if (sel_ready_s || timeout_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = ACCESS;
                end
            end
            DONE: begin
                cpu_rdata   = rdata_r;
                cpu_err     = err_r;
                state_nxt_s = IDLE;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // APB request capture, handshake strobes, timeout counter and completion latch.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            idx_r     <= '0;
            paddr_r   <= '0;
            pwdata_r  <= '0;
            pwrite_r  <= 1'b0;
            psel_r    <= '0;
            penable_r <= 1'b0;
            rdata_r   <= 32'h0000_0000;
            err_r     <= 1'b0;
            cnt_r     <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (launch_s) begin
                        idx_r    <= idx_s;
                        paddr_r  <= cpu_addr[PADDR_W-1:0];
                        pwdata_r <= cpu_wdata[PDATA_W-1:0];
                        pwrite_r <= cpu_mem_write;
                        psel_r   <= N_SLV'(onehot32(5'(idx_s)));
                        cnt_r    <= '0;
                    end
                end
                SETUP: penable_r <= 1'b1;
                ACCESS: begin
                    cnt_r <= cnt_r + CNT_W'(1'b1);
                    if (sel_ready_s) begin
                        rdata_r   <= 32'(sel_rdata_s);
                        err_r     <= sel_err_s;
                        psel_r    <= '0;
                        penable_r <= 1'b0;
                    end else if (timeout_s) begin
                        rdata_r   <= 32'h0000_0000;
                        err_r     <= 1'b1;
                        psel_r    <= '0;
                        penable_r <= 1'b0;
                    end
                end
                DONE: cnt_r <= '0;
                default: begin
                    psel_r    <= '0;
                    penable_r <= 1'b0;
                end
            endcase
        end
    end

endmodule
